load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit for the RISC-V CPU, sitting between the execute stage and the word-addressed data memory (combinational read, synchronous write). It accepts one load or store request at a time over a valid/ready handshake and drives the memory's write-enable, address and write-data ports. It performs byte/halfword lane extraction with sign or zero extension for loads, and read-modify-write for sub-word stores. It returns a single-cycle response pulse carrying load data or a misalignment/illegal error.

## Interface
- `DATA_WIDTH`, 32, data word width (fixed at 32; byte lanes assume 4 bytes)
- `ADDR_WIDTH`, 32, byte-address width
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RISC-V funct3 size/sign code
- `req_addr`  in  ADDR_WIDTH  byte address
- `req_wdata`  in  DATA_WIDTH  store data (low bytes used for SB/SH)
- `resp_valid`  out  1  one-cycle response pulse
- `resp_rdata`  out  DATA_WIDTH  extended load data (0 for stores/errors)
- `resp_err`  out  1  misaligned or illegal funct3
- `mem_wr_en`  out  1  memory write enable
- `mem_addr`  out  ADDR_WIDTH  word-aligned byte address to memory, bits [1:0] always 0
- `mem_wr_data`  out  DATA_WIDTH  full word to write
- `mem_rd_data`  in  DATA_WIDTH  combinational read data for `mem_addr`

## Operation
- States: IDLE, ACCESS, WRITE, RESP. `req_ready` = 1 only in IDLE.
- Legal loads:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores:
  - 000 SB, 001 SH, 010 SW.
- Any other funct3 is an error.
- Alignment:
  - Halfword requires `addr[0]=0`.
  - Word requires `addr[1:0]=00`.
  - Violation is an error.
- IDLE: on `req_valid & req_ready`, latch we, funct3, addr, wdata.
  - Error: next state RESP with err=1, rdata=0. No memory write ever occurs.
  - Otherwise: next state ACCESS.
- ACCESS: `mem_addr` = {latched addr[ADDR_WIDTH-1:2], 2'b00}.
  - Load: extract lane `addr[1:0]` (byte) or `addr[1]` (half) from `mem_rd_data`. Sign-extend (LB/LH) or zero-extend (LBU/LHU), register it into `resp_rdata`, then go to RESP.
  - SW: `mem_wr_en`=1, `mem_wr_data`=wdata, then go to RESP.
  - SB/SH: register the merged word (`mem_rd_data` with the addressed lane replaced by wdata[7:0] / wdata[15:0]), then go to WRITE.
- WRITE: `mem_wr_en`=1, `mem_wr_data`=merged word, same `mem_addr`. Then go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then go to IDLE. There is no response backpressure.
- `mem_wr_en` is asserted only in ACCESS (SW) and WRITE. It is at most one cycle per request.
- `resp_rdata`/`resp_err` are registered. They hold their value until the next response is loaded.

## Timing
- Reset (async, immediate): state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0.
- Reset asserted mid-request abandons the request. No write occurs after reset asserts, and no response is produced.
- Latency from the accepting edge to `resp_valid`:
  - Error: 1 cycle.
  - Load and SW: 2 cycles.
  - SB/SH: 3 cycles.
- Next accept: earliest on the cycle after RESP. Back-to-back throughput is one request per 3 cycles (loads/SW) or 4 cycles (SB/SH).
- `req_*` inputs are ignored while `req_ready`=0. Inputs are sampled only at the accepting edge, so later changes have no effect.
- Memory outputs are driven from state and latched registers only. They have no combinational path from `req_*`.
- Memory wrap-around/aliasing is the memory's concern. The unit passes the full address through.

## Test plan
- Preload mem[word 1] = 0x8765_43A1. LB addr 0x4 → rdata 0xFFFF_FFA1. LBU addr 0x4 → 0x0000_00A1. LH addr 0x6 → 0xFFFF_8765. LHU addr 0x6 → 0x0000_8765. Each returns resp 2 cycles after acceptance with err=0.
- SW 0xDEAD_BEEF @0x8 → exactly one `mem_wr_en` pulse with mem_addr=0x8, resp at +2 cycles. A following LW @0x8 → 0xDEAD_BEEF.
- mem[word 2]=0x1122_3344. SB wdata 0xAB @0xA → word becomes 0x11AB_3344. SH wdata 0xCDEF @0x8 → word becomes 0x11AB_CDEF. Each has a single write pulse and resp at +3 cycles.
- LW @0x2, SH @0x5, funct3 011 load → err=1, rdata=0, resp at +1 cycle, `mem_wr_en` never asserted, memory unchanged.
- `req_valid` held high with changing data during a busy period → only the first request is accepted. `req_ready` is 0 until the cycle after RESP.
- Drop `rst_n` during the ACCESS cycle of an SB → `mem_wr_en` goes low immediately, no write and no `resp_valid`. After release, `req_ready`=1 and memory is unchanged.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-addressed data memory.
// Handles byte/halfword lane extraction with extension, and read-modify-write for SB/SH.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] merge_q, merge_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic                  req_illegal;
  logic                  req_misaligned;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic [DATA_WIDTH-1:0] st_merged;
  logic                  is_sw_q;

  // Request decode looks only at the live inputs; it is consulted solely in IDLE.
  always_comb begin
    if (req_we) begin
      req_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    end else begin
      req_illegal = (req_funct3[1:0] == 2'b11) | (req_funct3[2] & req_funct3[1]);
    end
    req_misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0])
                   | ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_rd_data[7:0];
      2'b01:   ld_byte = mem_rd_data[15:8];
      2'b10:   ld_byte = mem_rd_data[23:16];
      default: ld_byte = mem_rd_data[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
  end

  always_comb begin
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rd_data;
    endcase
  end

  // Sub-word store: the current memory word with only the addressed lane replaced.
  always_comb begin
    st_merged = mem_rd_data;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'b00:   st_merged[7:0]   = wdata_q[7:0];
        2'b01:   st_merged[15:8]  = wdata_q[7:0];
        2'b10:   st_merged[23:16] = wdata_q[7:0];
        default: st_merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      st_merged[31:16] = wdata_q[15:0];
    end else begin
      st_merged[15:0] = wdata_q[15:0];
    end
  end

  assign is_sw_q = we_q & (funct3_q[1:0] == 2'b10);

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (req_illegal | req_misaligned) begin
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = S_RESP;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          resp_rdata_d = ld_ext;
          resp_err_d   = 1'b0;
          state_d      = S_RESP;
        end else if (is_sw_q) begin
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          state_d      = S_RESP;
        end else begin
          merge_d = st_merged;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        state_d      = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Memory port is a function of state and latched fields only, never of req_*.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    if (state_q == S_WRITE) begin
      mem_wr_en   = 1'b1;
      mem_wr_data = merge_q;
    end else if ((state_q == S_ACCESS) && is_sw_q) begin
      mem_wr_en   = 1'b1;
      mem_wr_data = wdata_q;
    end
  end

  assign mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word-addressed memory, arithmetic reference model,
// and one per-cycle compare process against the model's expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  // Data memory seen by the DUT: combinational read, write on the clock edge.
  logic [31:0] mem [0:15];
  assign mem_rd_data = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[5:2]] <= mem_wr_data;

  // Reference model state
  logic [31:0] ref_mem [0:15];
  int          cyc = 0;
  int          exp_resp_cyc = -1;
  int          exp_wr_cyc = -1;
  logic        exp_err = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic [31:0] exp_wr_addr = 32'd0;
  logic [31:0] exp_wr_data = 32'd0;
  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;
  int          n_vec = 0;
  int          n_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wr_data", mem_wr_data, 32'd0);
    end else begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, cyc > exp_resp_cyc});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, cyc == exp_resp_cyc});
      if (resp_valid) begin
        last_rdata = resp_rdata;
        last_err   = resp_err;
      end
      if (cyc == exp_resp_cyc) begin
        chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
        chk("resp_rdata", resp_rdata, exp_rdata);
      end
      chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, cyc == exp_wr_cyc});
      if (cyc == exp_wr_cyc) begin
        chk("mem_addr", mem_addr, exp_wr_addr);
        chk("mem_wr_data", mem_wr_data, exp_wr_data);
      end
    end
  end

  // Issue one request and set the model's expectations from the RISC-V rules.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, input bit abort);
    int          guard;
    int          acc;
    int          lat;
    logic [1:0]  size;
    logic [4:0]  sh;
    bit          legal;
    bit          mis;
    logic [31:0] w;
    logic [31:0] v;
    logic [31:0] mask;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: req_ready stayed 0, required 1");
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    acc   = cyc;
    size  = f3[1:0];
    sh    = {a[1:0], 3'b000};
    legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis   = (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'd0);
    w     = ref_mem[a[5:2]];
    exp_wr_cyc = -1;
    exp_err    = 1'b0;
    exp_rdata  = 32'd0;
    if (!legal || mis) begin
      exp_err = 1'b1;
      lat     = 1;
    end else if (!we) begin
      lat = 2;
      if (size == 2'd2) begin
        v = w;
      end else if (size == 2'd0) begin
        v = (w >> sh) & 32'hFF;
        if (!f3[2] && v >= 32'd128) v = v - 32'd256;
      end else begin
        v = (w >> sh) & 32'hFFFF;
        if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
      end
      exp_rdata = v;
    end else begin
      mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      v = (size == 2'd2) ? wd : ((w & ~(mask << sh)) | ((wd & mask) << sh));
      exp_wr_addr = {a[31:2], 2'b00};
      exp_wr_data = v;
      exp_wr_cyc  = (size == 2'd2) ? acc : acc + 1;
      lat         = (size == 2'd2) ? 2 : 3;
      if (!abort) ref_mem[a[5:2]] = v;
    end
    exp_resp_cyc = acc + lat - 1;

    if (abort) begin
      #1;
      exp_resp_cyc = -1;
      exp_wr_cyc   = -1;
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      #1;
      chk("abort_wr_en", {31'd0, mem_wr_en}, 32'd0);
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      return;
    end

    if (hold) begin
      guard = 0;
      while (guard < 20) begin
        @(negedge clk);
        if (cyc == exp_resp_cyc) break;
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        guard++;
      end
    end
    req_valid = 1'b0;

    guard = 0;
    while (cyc <= exp_resp_cyc && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc <= exp_resp_cyc) begin
      n_vec++;
      n_miss++;
      $display("FAIL resp_timeout: no completion by cycle %0d, required by %0d", cyc, exp_resp_cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     <= 32'h0101_0101 * i;
      ref_mem[i] = 32'h0101_0101 * i;
    end
    mem[1]     <= 32'h8765_43A1;
    ref_mem[1] = 32'h8765_43A1;
    mem[2]     <= 32'h1122_3344;
    ref_mem[2] = 32'h1122_3344;
    #22;
    rst_n = 1'b1;

    // Loads from word 1
    do_req(1'b0, 3'b000, 32'h4, 32'h0, 1'b0, 1'b0);
    chk("lit_LB_4", last_rdata, 32'hFFFF_FFA1);
    do_req(1'b0, 3'b100, 32'h4, 32'h0, 1'b0, 1'b0);
    chk("lit_LBU_4", last_rdata, 32'h0000_00A1);
    do_req(1'b0, 3'b001, 32'h6, 32'h0, 1'b0, 1'b0);
    chk("lit_LH_6", last_rdata, 32'hFFFF_8765);
    do_req(1'b0, 3'b101, 32'h6, 32'h0, 1'b0, 1'b0);
    chk("lit_LHU_6", last_rdata, 32'h0000_8765);
    do_req(1'b0, 3'b000, 32'h7, 32'h0, 1'b0, 1'b0);
    chk("lit_LB_7", last_rdata, 32'hFFFF_FF87);
    do_req(1'b0, 3'b000, 32'h5, 32'h0, 1'b0, 1'b0);
    chk("lit_LB_5", last_rdata, 32'h0000_0043);
    do_req(1'b0, 3'b001, 32'h4, 32'h0, 1'b0, 1'b0);
    chk("lit_LH_4", last_rdata, 32'h0000_43A1);
    do_req(1'b0, 3'b010, 32'h4, 32'h0, 1'b0, 1'b0);
    chk("lit_LW_4", last_rdata, 32'h8765_43A1);

    // Sub-word stores into word 2
    do_req(1'b1, 3'b000, 32'hA, 32'h0000_00AB, 1'b0, 1'b0);
    chk("lit_SB_A", mem[2], 32'h11AB_3344);
    do_req(1'b1, 3'b001, 32'h8, 32'h0000_CDEF, 1'b0, 1'b0);
    chk("lit_SH_8", mem[2], 32'h11AB_CDEF);
    do_req(1'b1, 3'b000, 32'hF, 32'h1234_56C3, 1'b0, 1'b0);
    do_req(1'b1, 3'b001, 32'h12, 32'hFFFF_9A5B, 1'b0, 1'b0);

    // Full-word store and read-back
    do_req(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_req(1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 1'b0);
    chk("lit_LW_8", last_rdata, 32'hDEAD_BEEF);

    // Errors: misaligned and illegal funct3, none may write
    do_req(1'b0, 3'b010, 32'h2, 32'h0, 1'b0, 1'b0);
    chk("lit_err_LW_2", {31'd0, last_err}, 32'd1);
    do_req(1'b1, 3'b001, 32'h5, 32'h5555_5555, 1'b0, 1'b0);
    do_req(1'b0, 3'b011, 32'h4, 32'h0, 1'b0, 1'b0);
    do_req(1'b1, 3'b100, 32'hC, 32'h7777_7777, 1'b0, 1'b0);
    do_req(1'b0, 3'b101, 32'h3, 32'h0, 1'b0, 1'b0);
    chk("lit_err_rdata", last_rdata, 32'd0);

    // Valid held high with changing fields while busy
    do_req(1'b1, 3'b000, 32'hD, 32'h0000_005A, 1'b1, 1'b0);
    do_req(1'b0, 3'b010, 32'hC, 32'h0, 1'b1, 1'b0);

    // Reset dropped during the ACCESS cycle of an SB
    do_req(1'b1, 3'b000, 32'hC, 32'h0000_0077, 1'b0, 1'b1);
    chk("abort_mem_w3", mem[3], ref_mem[3]);
    do_req(1'b0, 3'b010, 32'hC, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) chk($sformatf("final_mem_%0d", i), mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
